serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// Carries ovf only when SERIAL_SUBTRACTOR_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, d, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, d, bout, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, d, bout);
    modport slave  (input start, a, b, bin, output busy, done, d, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial d = a - b - bin, one full-subtractor cell reused LSB-first.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
//
//   state | meaning
//   IDLE  | waiting for start; operands latched on accept
//   SHIFT | one difference bit per cycle, LSB first
//   DONE  | result valid, done pulses for one cycle
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             diff;
    logic             brw_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             ovf_q, ovf_d;
`endif

    assign diff    = sa_q[0] ^ sb_q[0] ^ brw_q;
    assign brw_nxt = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    brw_d   = bus.bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    amsb_d  = bus.a[WIDTH-1];
                    bmsb_d  = bus.b[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                brw_d = brw_nxt;
                res_d = {diff, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    d_d     = res_d;
                    bout_d  = brw_nxt;
                    state_d = DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    // final diff bit is the result MSB
                    ovf_d   = (amsb_q ^ bmsb_q) & (diff ^ amsb_q);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    // status decoded from state so reset clears it without waiting for a clock
    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results queued at start, checked at done.
// Cycle timing, result hold, ignored starts and asynchronous reset are checked inline.
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];
    logic [W-1:0] prev_d;
    logic         prev_bout;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
        e.d    = full[W-1:0];
        e.bout = full[W];
        e.ovf  = (av[W-1] ^ bv[W-1]) & (e.d[W-1] ^ av[W-1]);
        return e;
    endfunction

    // scoreboard: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("d", 32'(bus.d), 32'(e.d));
                chk("bout", 32'(bus.bout), 32'(e.bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // one operation starting in the next cycle; intrude_at>0 pulses an illegal start in that busy cycle
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                         input int intrude_at);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.bin   = bi;
        e = model(av, bv, bi);
        sb_q.push_back(e);
        @(negedge clk);
        for (int i = 1; i <= W; i++) begin
            if (i == intrude_at) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF;
                bus.b     = 8'h01;
            end else begin
                bus.start = 1'b0;
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
            end
            bus.bin = 1'($urandom);
            chk("busy_shift", 32'(bus.busy), 32'd1);
            chk("done_early", 32'(bus.done), 32'd0);
            chk("d_hold", 32'(bus.d), 32'(prev_d));
            chk("bout_hold", 32'(bus.bout), 32'(prev_bout));
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("done_at_latency", 32'(bus.done), 32'd1);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        prev_d    = e.d;
        prev_bout = e.bout;
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("idle_done", 32'(bus.done), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        prev_d    = '0;
        prev_bout = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_d", 32'(bus.d), 32'd0);
        chk("rst_bout", 32'(bus.bout), 32'd0);

        do_op(8'h5A, 8'h3C, 1'b0, 0);
        idle_check(2);
        do_op(8'h3C, 8'h5A, 1'b0, 0);
        idle_check(1);

        // back-to-back: second start lands in the first IDLE cycle after DONE
        do_op(8'h00, 8'h00, 1'b1, 0);
        do_op(8'h7F, 8'h7F, 1'b0, 0);
        idle_check(1);

        do_op(8'h5A, 8'h3C, 1'b0, 4);
        idle_check(12);

        do_op(8'h80, 8'h01, 1'b0, 0);
        do_op(8'h05, 8'h03, 1'b0, 0);
        do_op(8'h7F, 8'hFF, 1'b0, 0);
        do_op(8'hFF, 8'hFF, 1'b1, 0);
        for (int k = 0; k < 6; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 0);
        end
        idle_check(1);

        // asynchronous reset in the middle of a shift
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h5A;
        bus.b     = 8'h3C;
        bus.bin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_done", 32'(bus.done), 32'd0);
        chk("async_rst_d", 32'(bus.d), 32'd0);
        chk("async_rst_bout", 32'(bus.bout), 32'd0);
        prev_d    = '0;
        prev_bout = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h10, 8'h01, 1'b0, 0);
        idle_check(3);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
